// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit 7-segment time-multiplexing scanner with
// double-buffered display contents committed at frame boundaries.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous reset, active-high
//   i_value[15:0]  four hex nibbles, [3:0] = digit 0 (rightmost)
//   i_dp[3:0]      decimal point per digit
//   i_update       stage request, value sampled while high
//   o_update_ack   pulse when the staged value is committed
//   o_frame_start  pulse at each frame boundary
//   o_LED[7:0]     segments {dp,g,f,e,d,c,b,a}
//   o_digitSelect  one-hot digit enable
//
// Optional macro SEG7_LZB_EN: leading-zero blanking on digits 3..1.

module seg7_scan_ctrl #(
   parameter int SCAN_DIV       = 4,
   parameter int BLANK_CYCLES   = 1,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit DIG_ACTIVE_LOW = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_value,
   input  logic [3:0]  i_dp,
   input  logic        i_update,
   output logic        o_update_ack,
   output logic        o_frame_start,
   output logic [7:0]  o_LED,
   output logic [3:0]  o_digitSelect
);

   localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
   localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
   localparam logic [7:0]  LED_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [3:0]  DIG_OFF    = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

   typedef enum logic {
      ST_BLANK,
      ST_DRIVE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] shd_v_q, shd_v_d;
   logic [3:0]  shd_dp_q, shd_dp_d;
   logic [15:0] stg_v_q, stg_v_d;
   logic [3:0]  stg_dp_q, stg_dp_d;
   logic        pend_q, pend_d;
   logic        ack_d, fs_d;
   logic [7:0]  led_d;
   logic [3:0]  sel_d;
   logic [7:0]  seg_on;
   logic [3:0]  lzb;
   logic [3:0]  nib;

   function automatic logic [6:0] dec(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

`ifdef SEG7_LZB_EN
   // A digit is blank when it and every higher nibble are zero.
   assign lzb[0] = 1'b0;
   assign lzb[1] = (shd_v_q[15:4] == 12'h000);
   assign lzb[2] = (shd_v_q[15:8] == 8'h00);
   assign lzb[3] = (shd_v_q[15:12] == 4'h0);
`else
   assign lzb = 4'b0000;
`endif

   assign nib = shd_v_q[{idx_q, 2'b00} +: 4];
   assign seg_on = {shd_dp_q[idx_q],
                    lzb[idx_q] ? 7'h00 : dec(nib)};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 16'd1;
      idx_d    = idx_q;
      shd_v_d  = shd_v_q;
      shd_dp_d = shd_dp_q;
      stg_v_d  = stg_v_q;
      stg_dp_d = stg_dp_q;
      pend_d   = pend_q;
      ack_d    = 1'b0;
      fs_d     = 1'b0;
      led_d    = LED_OFF;
      sel_d    = DIG_OFF;

      unique case (state_q)
         ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = ST_DRIVE;
               cnt_d   = 16'd0;
               led_d   = seg_on ^ LED_OFF;
               sel_d   = (4'b0001 << idx_q) ^ DIG_OFF;
            end
         end
         ST_DRIVE: begin
            led_d = seg_on ^ LED_OFF;
            sel_d = (4'b0001 << idx_q) ^ DIG_OFF;
            if (cnt_q == SCAN_LAST) begin
               state_d = ST_BLANK;
               cnt_d   = 16'd0;
               idx_d   = idx_q + 2'd1;
               led_d   = LED_OFF;
               sel_d   = DIG_OFF;
               // Leaving digit 3 is the frame boundary.
               if (idx_q == 2'd3) begin
                  fs_d = 1'b1;
                  if (pend_q) begin
                     shd_v_d  = stg_v_q;
                     shd_dp_d = stg_dp_q;
                     pend_d   = 1'b0;
                     ack_d    = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = ST_BLANK;
            cnt_d   = 16'd0;
         end
      endcase

      // A request on the boundary cycle restages after the commit.
      if (i_update) begin
         stg_v_d  = i_value;
         stg_dp_d = i_dp;
         pend_d   = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= ST_BLANK;
         cnt_q         <= 16'd0;
         idx_q         <= 2'd0;
         shd_v_q       <= 16'h0000;
         shd_dp_q      <= 4'h0;
         stg_v_q       <= 16'h0000;
         stg_dp_q      <= 4'h0;
         pend_q        <= 1'b0;
         o_update_ack  <= 1'b0;
         o_frame_start <= 1'b0;
         o_LED         <= LED_OFF;
         o_digitSelect <= DIG_OFF;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         shd_v_q       <= shd_v_d;
         shd_dp_q      <= shd_dp_d;
         stg_v_q       <= stg_v_d;
         stg_dp_q      <= stg_dp_d;
         pend_q        <= pend_d;
         o_update_ack  <= ack_d;
         o_frame_start <= fs_d;
         o_LED         <= led_d;
         o_digitSelect <= sel_d;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: table vectors, directed corner sequences and
// random traffic against a slot/time based reference model.

module tb_seg7_scan_ctrl;

   localparam int S = 4;
   localparam int B = 1;
   localparam int SLOT = S + B;
   localparam int P = 4 * SLOT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value = 16'h0;
   logic [3:0]  dp = 4'h0;
   logic        upd = 1'b0;
   logic        ack, fs;
   logic [7:0]  led;
   logic [3:0]  sel;

   seg7_scan_ctrl #(
      .SCAN_DIV(S),
      .BLANK_CYCLES(B),
      .SEG_ACTIVE_LOW(1'b0),
      .DIG_ACTIVE_LOW(1'b0)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_value(value),
      .i_dp(dp),
      .i_update(upd),
      .o_update_ack(ack),
      .o_frame_start(fs),
      .o_LED(led),
      .o_digitSelect(sel)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [6:0] seg_tab [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Reference model: time since reset plus committed/staged words.
   int          t;
   logic [15:0] m_shv, m_stv;
   logic [3:0]  m_shd, m_std;
   bit          m_pend;
   logic [7:0]  e_led;
   logic [3:0]  e_sel;
   bit          e_ack, e_fs;

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s t=%0d act=%h exp=%h", nm, t, act, exp);
      end
   endtask

   task automatic model_step(bit r, bit u, logic [15:0] v,
                             logic [3:0] d);
      int p, slot, q;
      logic [15:0] hi;
      logic [6:0] s;
      e_ack = 0;
      e_fs = 0;
      if (r) begin
         t = 0;
         m_shv = 0; m_shd = 0; m_stv = 0; m_std = 0;
         m_pend = 0;
      end else begin
         t++;
         if (t % P == 0) begin
            e_fs = 1;
            if (m_pend) begin
               e_ack = 1;
               m_shv = m_stv;
               m_shd = m_std;
               m_pend = 0;
            end
         end
         if (u) begin
            m_stv = v;
            m_std = d;
            m_pend = 1;
         end
      end
      p = t % P;
      slot = p / SLOT;
      q = p % SLOT;
      if (q < B) begin
         e_led = 8'h00;
         e_sel = 4'h0;
      end else begin
         hi = m_shv >> (4 * slot);
         s = seg_tab[hi[3:0]];
`ifdef SEG7_LZB_EN
         if (slot > 0 && hi == 16'h0) s = 7'h00;
`endif
         e_led = {m_shd[slot], s};
         e_sel = 4'(1 << slot);
      end
   endtask

   task automatic tick();
      bit r, u;
      logic [15:0] v;
      logic [3:0] d;
      r = rst; u = upd; v = value; d = dp;
      @(posedge clk);
      #1;
      model_step(r, u, v, d);
      chk("led", int'(led), int'(e_led));
      chk("sel", int'(sel), int'(e_sel));
      chk("ack", int'(ack), int'(e_ack));
      chk("frame_start", int'(fs), int'(e_fs));
   endtask

   task automatic stage(logic [15:0] v, logic [3:0] d);
      value = v; dp = d; upd = 1;
      tick();
      upd = 0;
   endtask

   typedef struct {
      logic [15:0] v;
      logic [3:0]  d;
      logic [7:0]  l [4];
   } vec_t;

   vec_t vt [6];
   logic [7:0] got [4];
   int acks;
   bit seen;

   initial begin
      vt[0] = '{16'h12AF, 4'b0100, '{8'h71, 8'h77, 8'hDB, 8'h06}};
      vt[1] = '{16'h2222, 4'b0000, '{8'h5B, 8'h5B, 8'h5B, 8'h5B}};
      vt[2] = '{16'h89CE, 4'b1011, '{8'hF9, 8'hB9, 8'h6F, 8'hFF}};
      vt[3] = '{16'h3456, 4'b0000, '{8'h7D, 8'h6D, 8'h66, 8'h4F}};
      vt[4] = '{16'h7BD0, 4'b0001, '{8'hBF, 8'h5E, 8'h7C, 8'h07}};
`ifdef SEG7_LZB_EN
      vt[5] = '{16'h0050, 4'b0000, '{8'h3F, 8'h6D, 8'h00, 8'h00}};
`else
      vt[5] = '{16'h0050, 4'b0000, '{8'h3F, 8'h6D, 8'h3F, 8'h3F}};
`endif

      // Reset state and first frame timing.
      rst = 1;
      tick();
      chk("rst_led", int'(led), 0);
      chk("rst_sel", int'(sel), 0);
      rst = 0;
      for (int i = 1; i <= P; i++) begin
         tick();
         if (i == 1) begin
            chk("first_sel", int'(sel), 1);
            chk("first_led", int'(led), 'h3F);
         end
         if (i == 6) chk("slot1_sel", int'(sel), 2);
         if (i == P) chk("frame_pulse", int'(fs), 1);
      end

      // Table vectors: stage mid-frame, wait for ack, read a frame.
      foreach (vt[k]) begin
         while (t % P != 7) tick();
         stage(vt[k].v, vt[k].d);
         seen = 0;
         for (int c = 0; c < 3 * P && !seen; c++) begin
            tick();
            if (ack) begin
               seen = 1;
               chk("ack_with_fs", int'(fs), 1);
            end
         end
         chk("ack_seen", int'(seen), 1);
         for (int c = 0; c < P; c++) begin
            tick();
            for (int n = 0; n < 4; n++)
               if (sel == 4'(1 << n)) got[n] = led;
         end
         for (int n = 0; n < 4; n++)
            chk($sformatf("vec%0d_d%0d", k, n),
                int'(got[n]), int'(vt[k].l[n]));
      end

      // Two requests in one frame: single ack.
      while (t % P != 2) tick();
      stage(16'h1111, 4'h0);
      tick(); tick();
      stage(16'h2222, 4'h0);
      acks = 0;
      for (int c = 0; c < 2 * P; c++) begin
         tick();
         if (ack) acks++;
      end
      chk("double_req_acks", acks, 1);

      // Request exactly on the boundary cycle.
      while (t % P != 3) tick();
      stage(16'h0001, 4'h0);
      while (t % P != P - 1) tick();
      stage(16'h0BEE, 4'h2);
      chk("bnd_ack_now", int'(ack), 1);
      acks = 0;
      for (int c = 1; c <= P; c++) begin
         tick();
         if (ack) begin
            acks++;
            chk("bnd_ack_late_pos", c, P);
         end
      end
      chk("bnd_ack_late_cnt", acks, 1);

      // Reset during digit 2 with a request pending.
      while (t % P != 3) tick();
      stage(16'h9999, 4'hF);
      while (t % P != 2 * SLOT + B + 1) tick();
      chk("pre_rst_sel", int'(sel), 4);
      rst = 1;
      tick();
      chk("mid_rst_led", int'(led), 0);
      chk("mid_rst_sel", int'(sel), 0);
      rst = 0;
      acks = 0;
      for (int c = 1; c <= 3 * P; c++) begin
         tick();
         if (ack) acks++;
         if (c == 1) chk("restart_led", int'(led), 'h3F);
      end
      chk("discard_no_ack", acks, 0);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         upd = ($urandom_range(0, 5) == 0);
         value = 16'($urandom);
         dp = 4'($urandom);
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 0;
      upd = 0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout t=%0d", t);
      $fatal(1, "timeout");
   end

endmodule
